// File: rtl/ksa_pkg.sv
// ksa_pkg: shared constants for the PRESENT key schedule.
//   KEY_W      key register width (80, or 128 when KSA_KEY128_EN is defined)
//   RK_W       round-key width
//   NUM_SBOX   S-boxes applied per update (1 for 80-bit, 2 for 128-bit keys)
//   RC_LSB     bit position where round[4:0] is XORed in
//   SBOX       PRESENT S-box, index = 4-bit input
//   LAST_ROUND last round value that steps the register
//   ROUNDS_OUT number of round keys produced
// Macro: KSA_KEY128_EN selects the 128-bit key variant.
package ksa_pkg;
`ifdef KSA_KEY128_EN
  localparam int KEY_W    = 128;
  localparam int NUM_SBOX = 2;
  localparam int RC_LSB   = 62;
`else
  localparam int KEY_W    = 80;
  localparam int NUM_SBOX = 1;
  localparam int RC_LSB   = 15;
`endif
  localparam int RK_W = 64;

  localparam logic [5:0] LAST_ROUND = 6'd31;
  localparam logic [5:0] ROUNDS_OUT = 6'd32;

  // Packed with index 15 first, so SBOX[0] = C.
  localparam logic [15:0][3:0] SBOX = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };
endpackage

// File: rtl/ksa_if.sv
// ksa_if: key-schedule bus.
//   key, round              driven by the datapath (master)
//   new_key, key_state, valid driven by the key schedule (slave)
interface ksa_if;
  import ksa_pkg::*;
  logic [KEY_W-1:0] key;
  logic [5:0]       round;
  logic [RK_W-1:0]  new_key;
  logic [KEY_W-1:0] key_state;
  logic             valid;

  modport master (output key, round, input new_key, key_state, valid);
  modport slave  (input key, round, output new_key, key_state, valid);
endinterface

// File: rtl/present_sbox.sv
// present_sbox: 4-bit combinational PRESENT S-box lookup.
//   din   4-bit input nibble
//   dout  substituted nibble
module present_sbox
  import ksa_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = SBOX[din];
endmodule

// File: rtl/ksa.sv
// ksa: iterative PRESENT key schedule, one 64-bit round key per clock.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    ksa_if.slave: key/round in; new_key/key_state/valid out
// round == 0 loads key; rounds 1..31 step the register; 32..63 hold.
// Macro: KSA_KEY128_EN selects the 128-bit key register and update rule.
module ksa
  import ksa_pkg::*;
(
  input  logic clk,
  input  logic reset,
  ksa_if.slave bus
);
  logic [KEY_W-1:0]          ks;
  logic [KEY_W-1:0]          rot;
  logic [KEY_W-1:0]          nxt;
  logic [NUM_SBOX-1:0][3:0]  sb;
  logic                      vld;
  logic                      step;

  // Rotate left by 61 is pure wiring.
  assign rot = {ks[KEY_W-62:0], ks[KEY_W-1 -: 61]};

  // Top nibble(s) of the rotated key go through the S-box.
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    present_sbox u_sbox (
      .din  (rot[KEY_W-1-4*g -: 4]),
      .dout (sb[g])
    );
  end

  always_comb begin
    nxt = rot;
    for (int i = 0; i < NUM_SBOX; i++)
      nxt[KEY_W-1-4*i -: 4] = sb[i];
    nxt[RC_LSB +: 5] = rot[RC_LSB +: 5] ^ bus.round[4:0];
  end

  assign step = (bus.round != 6'd0) && (bus.round <= LAST_ROUND);

  always_ff @(posedge clk) begin
    if (reset) begin
      ks  <= '0;
      vld <= 1'b0;
    end else if (bus.round == 6'd0) begin
      ks  <= bus.key;
      vld <= 1'b1;
    end else if (step) begin
      ks  <= nxt;
    end
  end

  assign bus.new_key   = ks[KEY_W-1 -: RK_W];
  assign bus.key_state = ks;
  assign bus.valid     = vld;
endmodule

// File: tb/tb_ksa.sv
// tb_ksa: directed self-checking bench for ksa.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_ksa;
  import ksa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ksa_if bus ();

  ksa dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sbx(input logic [3:0] x);
    case (x)
      4'h0: sbx = 4'hC; 4'h1: sbx = 4'h5; 4'h2: sbx = 4'h6; 4'h3: sbx = 4'hB;
      4'h4: sbx = 4'h9; 4'h5: sbx = 4'h0; 4'h6: sbx = 4'hA; 4'h7: sbx = 4'hD;
      4'h8: sbx = 4'h3; 4'h9: sbx = 4'hE; 4'hA: sbx = 4'hF; 4'hB: sbx = 4'h8;
      4'hC: sbx = 4'h4; 4'hD: sbx = 4'h7; 4'hE: sbx = 4'h1; default: sbx = 4'h2;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] upd(input logic [KEY_W-1:0] k, input logic [5:0] r);
    logic [KEY_W-1:0] t;
    t = (k << 61) | (k >> (KEY_W - 61));
    t[KEY_W-1 -: 4] = sbx(t[KEY_W-1 -: 4]);
`ifdef KSA_KEY128_EN
    t[123:120] = sbx(t[123:120]);
    t[66:62]   = t[66:62] ^ r[4:0];
`else
    t[19:15]   = t[19:15] ^ r[4:0];
`endif
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [KEY_W-1:0] m, input logic v);
    chk({tag, ".ks"},  128'(bus.key_state), 128'(m));
    chk({tag, ".rk"},  128'(bus.new_key),   128'(m[KEY_W-1 -: RK_W]));
    chk({tag, ".vld"}, 128'(bus.valid),     128'(v));
  endtask

  task automatic run_sched(input logic [KEY_W-1:0] k, input string tag);
    logic [KEY_W-1:0] m;
    bus.key = k; bus.round = 6'd0;
    tick();
    m = k;
    chk_all($sformatf("%s.K1", tag), m, 1'b1);
    for (int r = 1; r <= 31; r++) begin
      bus.round = 6'(r);
      tick();
      m = upd(m, 6'(r));
      chk_all($sformatf("%s.K%0d", tag, r + 1), m, 1'b1);
    end
    bus.round = ROUNDS_OUT;
    tick();
    chk_all($sformatf("%s.hold32", tag), m, 1'b1);
    bus.round = 6'd45;
    tick();
    chk_all($sformatf("%s.hold45", tag), m, 1'b1);
  endtask

  initial begin
    logic [127:0]     w;
    logic [KEY_W-1:0] k, k2, m;

    reset = 1'b1;
    bus.key = '1; bus.round = 6'd0;
    tick(); tick();
    chk_all("reset", '0, 1'b0);

    reset = 1'b0;
`ifdef KSA_KEY128_EN
    bus.key = '0; bus.round = 6'd0;
    tick();
    chk("z128.K1", 128'(bus.new_key), 128'h0);
    bus.round = 6'd1;
    tick();
    chk("z128.K2", 128'(bus.new_key), 128'hCC00000000000000);
`else
    bus.key = '0; bus.round = 6'd0;
    tick();
    chk("z80.K1", 128'(bus.new_key), 128'h0);
    bus.round = 6'd1;
    tick();
    chk("z80.ks2", 128'(bus.key_state), 128'hC0000000000000008000);
    chk("z80.K2",  128'(bus.new_key),   128'hC000000000000000);
    bus.key = '1; bus.round = 6'd0;
    tick();
    chk("o80.K1", 128'(bus.new_key), 128'hFFFFFFFFFFFFFFFF);
    bus.round = 6'd1;
    tick();
    chk("o80.ks2", 128'(bus.key_state), 128'h2FFFFFFFFFFFFFFF7FFF);
    chk("o80.K2",  128'(bus.new_key),   128'h2FFFFFFFFFFFFFFF);
`endif

    run_sched('0, "zero");
    run_sched('1, "ones");
    for (int i = 0; i < 3; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      k = w[KEY_W-1:0];
      run_sched(k, $sformatf("rnd%0d", i));
    end

    // Restart mid-schedule with a fresh key.
    w = 128'h0123456789ABCDEF_FEDCBA9876543210;
    k = w[KEY_W-1:0];
    w = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    k2 = w[KEY_W-1:0];
    bus.key = k; bus.round = 6'd0;
    tick();
    m = k;
    for (int r = 1; r <= 10; r++) begin
      bus.round = 6'(r);
      tick();
      m = upd(m, 6'(r));
    end
    chk_all("restart.pre", m, 1'b1);
    bus.key = k2; bus.round = 6'd0;
    tick();
    chk_all("restart.K1", k2, 1'b1);
    bus.round = 6'd1;
    tick();
    chk_all("restart.K2", upd(k2, 6'd1), 1'b1);

    // Reset beats a simultaneous load.
    reset = 1'b1; bus.key = k; bus.round = 6'd0;
    tick();
    chk_all("rst_vs_load", '0, 1'b0);
    reset = 1'b0; bus.round = 6'd5;
    tick();
    chk_all("post_rst_hold", upd('0, 6'd5), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
